// File: rtl/processor_pkg.sv
// Shared definitions for the 18-bit core fetch path: default widths, reset
// address and the packed layout of one fetch-queue entry.
package processor_pkg;

  localparam int          ADDR_SIZE_DEF = 18;
  localparam int          WORD_SIZE_DEF = 18;
  localparam int unsigned RESET_IP_DEF  = 0;

  // Entry layout is {instr, ip, ip_plus_one}, packed MSB first.
  localparam int ENTRY_W = WORD_SIZE_DEF + 2 * ADDR_SIZE_DEF;

  function automatic int entry_width(input int word_w, input int addr_w);
    return word_w + 2 * addr_w;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding fetched entries; flush empties it in one cycle and
// the head is read combinationally from storage (no write-to-read bypass).
module fetch_queue_fifo
  import processor_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_i) - CW'(do_pop);
    if (push_i) tail_d = tail_q + PW'(1);
    if (do_pop) head_d = head_q + PW'(1);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/processor_fetch_queue.sv
// Decoupled instruction prefetch: issues sequential code reads, queues the
// returned words with their ip/ip+1, and flushes on a taken jump or call.
module processor_fetch_queue
  import processor_pkg::*;
#(
  parameter int          ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int          WORD_SIZE = WORD_SIZE_DEF,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_IP  = RESET_IP_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_SIZE-1:0]   code_addr,
  output logic                   code_rd,
  input  logic [WORD_SIZE-1:0]   code_data,
  input  logic                   redirect,
  input  logic [ADDR_SIZE-1:0]   redirect_ip,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_instr,
  output logic [ADDR_SIZE-1:0]   out_ip,
  output logic [ADDR_SIZE-1:0]   out_ip_plus_one,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = entry_width(WORD_SIZE, ADDR_SIZE);

  logic [ADDR_SIZE-1:0] fetch_q, fetch_d;
  logic [ADDR_SIZE-1:0] tag_q;
  logic                 inflight_q;
  logic [OW-1:0]        occupancy;
  logic                 issue, kill, push, pop, fifo_full;
  logic [EW-1:0]        push_entry, head_entry;

  // Reserve a slot for the outstanding read so a return can never overflow.
  always_comb begin
    occupancy = {1'b0, count} + OW'(inflight_q);
    issue     = !reset && !redirect && (occupancy < OW'(DEPTH));
    kill      = redirect;
    push      = inflight_q && !kill && !fifo_full;
    pop       = out_valid && out_ready;
    fetch_d   = fetch_q;
    if (redirect)   fetch_d = redirect_ip;
    else if (issue) fetch_d = fetch_q + ADDR_SIZE'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q    <= ADDR_SIZE'(RESET_IP);
      inflight_q <= 1'b0;
    end else begin
      fetch_q    <= fetch_d;
      inflight_q <= issue;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) tag_q <= fetch_q;
  end

  assign push_entry = {code_data, tag_q, tag_q + ADDR_SIZE'(1)};

  fetch_queue_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .full_o      (fifo_full),
    .count_o     (count),
    .head_o      (head_entry)
  );

  assign code_addr = fetch_q;
  assign code_rd   = issue;
  assign out_valid = (count != '0);
  assign {out_instr, out_ip, out_ip_plus_one} = head_entry;

endmodule

// File: tb/tb_processor_fetch_queue.sv
// Scoreboard bench for processor_fetch_queue: expected ips are queued when
// stimulus is applied and popped whenever decode accepts the head.
module tb_processor_fetch_queue;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] code_addr;
  logic          code_rd;
  logic [WW-1:0] code_data = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_ip = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_instr;
  logic [AW-1:0] out_ip;
  logic [AW-1:0] out_ip_plus_one;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_ip, mon_ip1;

  processor_fetch_queue #(
    .ADDR_SIZE (AW),
    .WORD_SIZE (WW),
    .DEPTH     (DEPTH),
    .RESET_IP  (0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .code_addr       (code_addr),
    .code_rd         (code_rd),
    .code_data       (code_data),
    .redirect        (redirect),
    .redirect_ip     (redirect_ip),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_ip          (out_ip),
    .out_ip_plus_one (out_ip_plus_one),
    .count           (count)
  );

  always #5 clock = ~clock;

  function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
    return a + 18'h100;
  endfunction

  // Synchronous code memory: one-cycle read latency.
  always @(posedge clock) begin
    if (code_rd === 1'b1) code_data <= word_of(code_addr);
  end

  // Scoreboard: every accepted head must be the next expected ip.
  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      pops++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pop got ip=%h required no delivery", out_ip);
      end else begin
        mon_ip  = exp_q.pop_front();
        mon_ip1 = mon_ip + 18'd1;
        if (out_ip !== mon_ip) begin
          miscompares++;
          $display("FAIL pop_ip got %h required %h", out_ip, mon_ip);
        end
        vectors++;
        if (out_instr !== word_of(mon_ip)) begin
          miscompares++;
          $display("FAIL pop_instr got %h required %h", out_instr, word_of(mon_ip));
        end
        vectors++;
        if (out_ip_plus_one !== mon_ip1) begin
          miscompares++;
          $display("FAIL pop_ip_plus_one got %h required %h", out_ip_plus_one, mon_ip1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load_exp(input logic [AW-1:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + AW'(i));
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; redirect = 1'b0;
    repeat (3) cyc();
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || code_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got valid=%b count=%0d rd=%b required 0/0/0", out_valid, count, code_rd);
    end
    load_exp(18'd0, 40);
    reset = 1'b0; pops = 0;
    #1;
    vectors++;
    if (code_rd !== 1'b1 || code_addr !== 18'd0) begin
      miscompares++;
      $display("FAIL first_issue got rd=%b addr=%h required 1/0", code_rd, code_addr);
    end
    cyc();
    vectors++;
    if (code_addr !== 18'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL second_cycle got addr=%h valid=%b required 1/0", code_addr, out_valid);
    end
    cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 18'h100 || out_ip !== 18'd0 || out_ip_plus_one !== 18'd1) begin
      miscompares++;
      $display("FAIL first_valid got v=%b instr=%h ip=%h ip1=%h required 1/100/0/1", out_valid, out_instr, out_ip, out_ip_plus_one);
    end
    repeat (10) cyc();
    vectors++;
    if (pops !== 10 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL steady_throughput got pops=%0d count=%0d required 10/1", pops, count);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] iss[$];
    out_ready = 1'b0; reset = 1'b1;
    cyc(); cyc();
    load_exp(18'd0, 40);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (code_rd === 1'b1) iss.push_back(code_addr);
    end
    vectors++;
    if (iss.size() != 4) begin
      miscompares++;
      $display("FAIL issue_count got %0d required 4", iss.size());
    end
    for (int i = 0; i < iss.size() && i < 4; i++) begin
      vectors++;
      if (iss[i] !== AW'(i)) begin
        miscompares++;
        $display("FAIL issue_addr[%0d] got %h required %h", i, iss[i], AW'(i));
      end
    end
    vectors++;
    if (count !== 3'd4 || code_rd !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_hold got count=%0d rd=%b valid=%b required 4/0/1", count, code_rd, out_valid);
    end
    cyc();
    out_ready = 1'b1; pops = 0;
    repeat (8) cyc();
    vectors++;
    if (pops !== 8) begin
      miscompares++;
      $display("FAIL drain_pops got %0d required 8", pops);
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0; reset = 1'b1;
    cyc(); cyc();
    load_exp(18'd0, 40);
    reset = 1'b0;
    repeat (4) cyc();
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL pre_redirect_count got %0d required 3", count);
    end
    redirect = 1'b1; redirect_ip = 18'h2A5;
    #1;
    vectors++;
    if (code_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_no_issue got rd=%b required 0", code_rd);
    end
    cyc();
    redirect = 1'b0;
    load_exp(18'h2A5, 40);
    out_ready = 1'b1; pops = 0;
    #1;
    vectors++;
    if (count !== 3'd0 || code_addr !== 18'h2A5 || code_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL redirect_flush got count=%0d addr=%h rd=%b required 0/2a5/1", count, code_addr, code_rd);
    end
    cyc(); cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_ip !== 18'h2A5) begin
      miscompares++;
      $display("FAIL redirect_head got v=%b ip=%h required 1/2a5", out_valid, out_ip);
    end
    repeat (5) cyc();
    vectors++;
    if (pops !== 5) begin
      miscompares++;
      $display("FAIL redirect_pops got %0d required 5", pops);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_ip = 18'h3FFFF;
    cyc();
    redirect = 1'b0;
    load_exp(18'h3FFFF, 40);
    #1;
    vectors++;
    if (code_addr !== 18'h3FFFF) begin
      miscompares++;
      $display("FAIL wrap_addr0 got %h required 3ffff", code_addr);
    end
    cyc();
    vectors++;
    if (code_addr !== 18'd0) begin
      miscompares++;
      $display("FAIL wrap_addr1 got %h required 0", code_addr);
    end
    cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_ip !== 18'h3FFFF || out_ip_plus_one !== 18'd0) begin
      miscompares++;
      $display("FAIL wrap_head got v=%b ip=%h ip1=%h required 1/3ffff/0", out_valid, out_ip, out_ip_plus_one);
    end
    cyc();
    vectors++;
    if (out_ip !== 18'd0) begin
      miscompares++;
      $display("FAIL wrap_next got %h required 0", out_ip);
    end
    repeat (3) cyc();
  endtask

  task automatic test_back_to_back_redirect();
    redirect = 1'b1; redirect_ip = 18'h10;
    cyc();
    redirect_ip = 18'h20;
    exp_q.delete();
    #1;
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_flush1 got count=%0d required 0", count);
    end
    cyc();
    redirect = 1'b0;
    load_exp(18'h20, 40);
    #1;
    vectors++;
    if (count !== 3'd0 || code_addr !== 18'h20) begin
      miscompares++;
      $display("FAIL b2b_flush2 got count=%0d addr=%h required 0/20", count, code_addr);
    end
    cyc(); cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_ip !== 18'h20) begin
      miscompares++;
      $display("FAIL b2b_head got v=%b ip=%h required 1/20", out_valid, out_ip);
    end
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    repeat (4) cyc();
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_pre_count got %0d required 3", count);
    end
    reset = 1'b1;
    cyc();
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || code_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b count=%0d rd=%b required 0/0/0", out_valid, count, code_rd);
    end
    cyc();
    load_exp(18'd0, 40);
    reset = 1'b0; out_ready = 1'b1; pops = 0;
    #1;
    vectors++;
    if (code_addr !== 18'd0 || code_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_restart got addr=%h rd=%b required 0/1", code_addr, code_rd);
    end
    cyc(); cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_ip !== 18'd0) begin
      miscompares++;
      $display("FAIL mid_head got v=%b ip=%h required 1/0", out_valid, out_ip);
    end
    repeat (4) cyc();
    vectors++;
    if (pops !== 4) begin
      miscompares++;
      $display("FAIL mid_pops got %0d required 4", pops);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back_redirect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
